regfile_sb: RTL



---
 rtl/regfile_sb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port GPR + HI/LO register file with a per-register busy
// scoreboard for the multi-issue core.
//
// Address map:
//   0       $zero
//   1-31    GPRs
//   32      HI/LO
//   33-63   unused
//
// Optional feature macro: REGFILE_BYPASS_EN.
//   Defined:   a same-cycle write is forwarded combinationally to all read
//              ports and to hilo_rd. Busy outputs show next-state busy.
//   Undefined: every output reflects registered state only.
//
// While resetn is low, all outputs are forced to zero.
module regfile_sb #(
    parameter int NREAD  = 16,
    parameter int NWRITE = 4,
    parameter int NALLOC = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREAD*6-1:0]    raddr,
    output logic [NREAD*32-1:0]   rdata,
    output logic [NREAD-1:0]      rbusy,
    output logic [63:0]           hilo_rd,
    output logic                  hilo_busy,
    input  logic [NWRITE-1:0]     we,
    input  logic [NWRITE*6-1:0]   waddr,
    input  logic [NWRITE*64-1:0]  wdata,
    input  logic [NALLOC-1:0]     alloc_v,
    input  logic [NALLOC*6-1:0]   alloc_addr
);

    localparam logic [5:0] HILO_IDX = 6'd32;

    // Entry 0 of gpr_q and bit 0 of busy_q are held at zero, so $zero needs
    // no special casing on the read side.
    logic [31:0][31:0] gpr_q, gpr_d;
    logic [63:0]       hilo_q, hilo_d;
    logic [32:0]       busy_q, busy_d;

    // Views used by the read side: registered state, or next state when bypassing.
    logic [31:0][31:0] gpr_view;
    logic [63:0]       hilo_view;
    logic [32:0]       busy_view;

    // Next-state computation.
    // Write ports are scanned in ascending order, so the highest-numbered
    // enabled port targeting an address overrides the lower ones.
    // Allocations are applied after the busy clears, so a same-cycle
    // producer keeps its register busy.
    always_comb begin
        logic [5:0] wa;
        logic [5:0] aa;

        wa     = '0;
        aa     = '0;
        gpr_d  = gpr_q;
        hilo_d = hilo_q;
        busy_d = busy_q;

        for (int j = 0; j < NWRITE; j++) begin
            wa = waddr[6*j +: 6];
            if (we[j]) begin
                if (wa != 6'd0 && wa < HILO_IDX) begin
                    gpr_d[wa[4:0]] = wdata[64*j +: 32];
                end else if (wa == HILO_IDX) begin
                    hilo_d = wdata[64*j +: 64];
                end
                if (wa != 6'd0 && wa <= HILO_IDX) begin
                    busy_d[wa] = 1'b0;
                end
            end
        end

        for (int k = 0; k < NALLOC; k++) begin
            aa = alloc_addr[6*k +: 6];
            if (alloc_v[k] && aa != 6'd0 && aa <= HILO_IDX) begin
                busy_d[aa] = 1'b1;
            end
        end

        gpr_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    // Architectural state: asynchronously cleared, otherwise loaded every edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gpr_q  <= '0;
            hilo_q <= '0;
            busy_q <= '0;
        end else begin
            gpr_q  <= gpr_d;
            hilo_q <= hilo_d;
            busy_q <= busy_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign gpr_view  = gpr_d;
    assign hilo_view = hilo_d;
    assign busy_view = busy_d;
`else
    assign gpr_view  = gpr_q;
    assign hilo_view = hilo_q;
    assign busy_view = busy_q;
`endif

    // Read ports.
    // Index 32 returns zero data but still reports HI/LO busy.
    // Unused addresses read as zero and not busy.
    always_comb begin
        logic [5:0] ra;

        ra        = '0;
        rdata     = '0;
        rbusy     = '0;
        hilo_rd   = '0;
        hilo_busy = 1'b0;

        if (resetn) begin
            hilo_rd   = hilo_view;
            hilo_busy = busy_view[32];
            for (int i = 0; i < NREAD; i++) begin
                ra = raddr[6*i +: 6];
                if (ra != 6'd0 && ra < HILO_IDX) begin
                    rdata[32*i +: 32] = gpr_view[ra[4:0]];
                    rbusy[i]          = busy_view[ra];
                end else if (ra == HILO_IDX) begin
                    rbusy[i] = busy_view[32];
                end
            end
        end
    end

endmodule
